// File: rtl/lab8_soc_pio_pkg.sv
// Shared constants for the lab8_soc PIO blocks: register word addresses,
// edge-type encodings and the register reset value.
package lab8_soc_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam logic [31:0] RST_VAL = 32'h0000_0000;

endpackage

// File: rtl/lab8_soc_game_in_if.sv
// Avalon-MM slave bus bundle for the game input port.
interface lab8_soc_game_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab8_soc_sync_edge.sv
// Synchronizer chain, one-cycle-delayed copy and edge detector with a
// post-reset warm-up window that blocks false captures.
module lab8_soc_sync_edge
  import lab8_soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int WARM  = SYNC_STAGES + 1;
  localparam int CNT_W = $clog2(WARM + 1);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] prev_p;
  logic [CNT_W-1:0] warm_cnt;
  logic             warm_done;
  logic [WIDTH-1:0] edge_raw;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= RST_VAL[WIDTH-1:0];
      prev_p   <= RST_VAL[WIDTH-1:0];
      warm_cnt <= '0;
    end else begin
      sync_p[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= sync_p[SYNC_STAGES-1];
      if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign data      = sync_p[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == CNT_W'(WARM));

  always_comb begin
    edge_raw = data & ~prev_p;
    if (EDGE_TYPE == EDGE_FALL)     edge_raw = ~data & prev_p;
    else if (EDGE_TYPE == EDGE_ANY) edge_raw = data ^ prev_p;
  end

  // Until the chain and prev have been refilled, data vs prev is meaningless.
  assign edge_pulse = warm_done ? edge_raw : '0;

endmodule

// File: rtl/lab8_soc_game_in.sv
// Avalon-MM input PIO: synchronized DATA, IRQMASK, sticky EDGECAP and a
// masked level interrupt.
module lab8_soc_game_in
  import lab8_soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  lab8_soc_game_in_if.slave   bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic             unused_wd;

  lab8_soc_sync_edge #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .data      (data),
    .edge_pulse(edge_pulse)
  );

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign cap_clr   = (wr_en && addr_e'(bus.address) == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wd = &{1'b0, bus.writedata};

  // A fresh edge overrides a clear landing on the same bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask <= RST_VAL[WIDTH-1:0];
      edge_cap <= RST_VAL[WIDTH-1:0];
    end else begin
      if (wr_en && addr_e'(bus.address) == ADDR_IRQMASK) irq_mask <= bus.writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
    end
  end

  always_comb begin
    bus.readdata = RST_VAL;
    if (reset_n && bus.chipselect) begin
      case (addr_e'(bus.address))
        ADDR_DATA:    bus.readdata[WIDTH-1:0] = data;
        ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irq_mask;
        ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edge_cap;
        default:      bus.readdata = RST_VAL;
      endcase
    end
  end

  assign irq = reset_n && (|(edge_cap & irq_mask));

endmodule

// File: tb/tb_lab8_soc_game_in.sv
// Bench for lab8_soc_game_in: rising, falling and any-edge builds side by side,
// directed register scenarios followed by randomized traffic against a model.
module tb_lab8_soc_game_in;
  import lab8_soc_pio_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic [1:0]   addr = 2'd0;
  logic         cs = 1'b0;
  logic         wn = 1'b1;
  logic [31:0]  wd = '0;
  logic [31:0]  rdv [3];
  logic         irqv [3];

  int n_chk  = 0;
  int n_pass = 0;

  lab8_soc_game_in_if bus0 ();
  lab8_soc_game_in_if bus1 ();
  lab8_soc_game_in_if bus2 ();

  assign bus0.address = addr; assign bus0.chipselect = cs; assign bus0.write_n = wn; assign bus0.writedata = wd;
  assign bus1.address = addr; assign bus1.chipselect = cs; assign bus1.write_n = wn; assign bus1.writedata = wd;
  assign bus2.address = addr; assign bus2.chipselect = cs; assign bus2.write_n = wn; assign bus2.writedata = wd;
  assign rdv[0] = bus0.readdata;
  assign rdv[1] = bus1.readdata;
  assign rdv[2] = bus2.readdata;

  always #5 clk = ~clk;

  lab8_soc_game_in #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irqv[0]));
  lab8_soc_game_in #(.WIDTH(W), .EDGE_TYPE(EDGE_FALL), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irqv[1]));
  lab8_soc_game_in #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irqv[2]));

  // Reference model: history of sampled inputs, edges since reset, per-build registers.
  logic [W-1:0] hist[$];
  int           edges_since_rst = 0;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_ecap [3] = '{default: '0};
  bit           auto_chk = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [W-1:0] m_data();
    return (hist.size() >= S) ? hist[hist.size()-S] : '0;
  endfunction

  function automatic logic [W-1:0] m_prev();
    return (hist.size() >= S+1) ? hist[hist.size()-S-1] : '0;
  endfunction

  function automatic logic [31:0] m_read(input int t);
    if (!reset_n || !cs) return 32'h0;
    case (addr)
      2'd0:    return {24'h0, m_data()};
      2'd2:    return {24'h0, m_mask};
      2'd3:    return {24'h0, m_ecap[t]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] d, p, clr, ev;
    if (!reset_n) begin
      hist.delete();
      edges_since_rst = 0;
      m_mask = '0;
      for (int t = 0; t < 3; t++) m_ecap[t] = '0;
    end else begin
      d   = m_data();
      p   = m_prev();
      clr = (cs && !wn && addr == 2'd3) ? wd[W-1:0] : '0;
      for (int t = 0; t < 3; t++) begin
        ev = (t == 0) ? (d & ~p) : (t == 1) ? (~d & p) : (d ^ p);
        if (edges_since_rst < S+1) ev = '0;
        m_ecap[t] = (m_ecap[t] & ~clr) | ev;
      end
      if (cs && !wn && addr == 2'd2) m_mask = wd[W-1:0];
      hist.push_back(in_port);
      if (hist.size() > S+1) void'(hist.pop_front());
      edges_since_rst++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (auto_chk) begin
      for (int t = 0; t < 3; t++) begin
        chk($sformatf("model_rd%0d_a%0d", t, addr), rdv[t], m_read(t));
        chk($sformatf("model_irq%0d", t), {31'h0, irqv[t]}, {31'h0, (|(m_ecap[t] & m_mask)) && reset_n});
      end
    end
  endtask

  task automatic sel(input logic [1:0] a);
    addr = a; cs = 1'b1; wn = 1'b1; #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wd = d; cs = 1'b1; wn = 1'b0;
    tick();
    wn = 1'b1;
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    cs = 1'b0; wn = 1'b1; in_port = v; reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (S+3) tick();
  endtask

  initial begin
    // Reset values, all addresses, while reset is held
    reset_n = 1'b0; in_port = '0;
    repeat (2) tick();
    for (int a = 0; a < 4; a++) begin
      sel(2'(a));
      chk($sformatf("rst_rd_a%0d", a), rdv[0], 32'h0);
    end
    chk("rst_irq", {31'h0, irqv[0]}, 32'h0);

    // Input high through reset release: warm-up blocks capture
    in_port = 8'hFF; tick();
    reset_n = 1'b1;
    repeat (6) tick();
    sel(2'd3);
    chk("warm_ecap_rise", rdv[0], 32'h0);
    chk("warm_ecap_any", rdv[2], 32'h0);
    sel(2'd0);
    chk("warm_data", rdv[0], 32'hFF);

    // Rising edges 0x00 -> 0xA5
    do_reset(8'h00);
    in_port = 8'hA5; sel(2'd0);
    tick(); tick();
    chk("data_a5", rdv[0], 32'hA5);
    sel(2'd3);
    chk("ecap_not_yet", rdv[0], 32'h0);
    tick();
    chk("ecap_a5", rdv[0], 32'hA5);
    chk("irq_unmasked", {31'h0, irqv[0]}, 32'h0);
    wr(2'd2, 32'h01);
    chk("irq_mask01", {31'h0, irqv[0]}, 32'h1);
    wr(2'd3, 32'h01);
    sel(2'd3);
    chk("ecap_clr01", rdv[0], 32'hA4);
    chk("irq_after_clr", {31'h0, irqv[0]}, 32'h0);
    wr(2'd2, 32'hFF);
    chk("irq_maskff", {31'h0, irqv[0]}, 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);
    sel(2'd3);
    chk("ecap_clrff", rdv[0], 32'h0);
    chk("irq_clrff", {31'h0, irqv[0]}, 32'h0);

    // Bit 3 edge coincides with a clear of bit 3
    in_port = 8'hAD;
    tick(); tick();
    wr(2'd3, 32'h08);
    sel(2'd3);
    chk("set_wins", rdv[0], 32'h08);
    chk("set_wins_irq", {31'h0, irqv[0]}, 32'h1);

    // Any-edge build, DATA is read-only, reserved word reads zero
    do_reset(8'h0F);
    in_port = 8'hF0;
    repeat (3) tick();
    sel(2'd3);
    chk("any_ecap", rdv[2], 32'hFF);
    chk("fall_ecap", rdv[1], 32'h0F);
    wr(2'd0, 32'h55);
    sel(2'd0);
    chk("data_ro", rdv[2], 32'hF0);
    sel(2'd1);
    chk("rsvd_zero", rdv[2], 32'h0);

    // Reset mid-operation
    do_reset(8'h00);
    in_port = 8'h3C;
    repeat (3) tick();
    wr(2'd2, 32'hFF);
    sel(2'd3);
    chk("pre_rst_ecap", rdv[0], 32'h3C);
    chk("pre_rst_irq", {31'h0, irqv[0]}, 32'h1);
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    sel(2'd3);
    chk("post_rst_ecap", rdv[0], 32'h0);
    sel(2'd2);
    chk("post_rst_mask", rdv[0], 32'h0);
    chk("post_rst_irq", {31'h0, irqv[0]}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      addr = 2'($urandom);
      cs   = ($urandom_range(0, 3) != 0);
      wn   = ($urandom_range(0, 2) != 0);
      wd   = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
